// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and types for the scoreboarded register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_NREGS = 32;
  localparam int DEFAULT_AW    = $clog2(DEFAULT_NREGS);

  typedef logic [DEFAULT_AW-1:0]    reg_addr_t;
  typedef logic [DEFAULT_WIDTH-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Pending-bit vector with set/clear, a running popcount and
//               the per-read-port busy lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = DEFAULT_NREGS,
  parameter int AW    = $clog2(NREGS),
  parameter int CW    = $clog2(NREGS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr_en,
  input  logic [AW-1:0] i_clr_a,
  input  logic          i_set_en,
  input  logic [AW-1:0] i_set_a,
  input  logic [AW-1:0] i_ra1,
  input  logic [AW-1:0] i_ra2,
  input  logic          i_fwd1,
  input  logic          i_fwd2,
  output logic          o_busy1,
  output logic          o_busy2,
  output logic [CW-1:0] o_pend_cnt
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;
  logic [CW-1:0]    r_cnt;
  logic             w_set;
  logic             w_clr;
  logic             w_inc;
  logic             w_dec;

  // Register 0 can never be reserved or released, so its bit stays 0.
  assign w_set = i_set_en && (i_set_a != '0);
  assign w_clr = i_clr_en && (i_clr_a != '0);

  // Clear first, then set: a same-edge reservation is a newer producer and wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_clr) w_pending_nxt[i_clr_a] = 1'b0;
    if (w_set) w_pending_nxt[i_set_a] = 1'b1;
  end

  // Counter deltas: only genuine 0->1 and 1->0 transitions move the count.
  assign w_inc = w_set && !r_pending[i_set_a];
  assign w_dec = w_clr && r_pending[i_clr_a] && !(w_set && (i_set_a == i_clr_a));

  // Pending vector and incrementally maintained popcount.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_cnt     <= r_cnt + CW'(w_inc) - CW'(w_dec);
    end
  end

  // A forwarded same-cycle write satisfies the reader, hiding the pending bit.
  assign o_busy1    = r_pending[i_ra1] & ~i_fwd1;
  assign o_busy2    = r_pending[i_ra2] & ~i_fwd2;
  assign o_pend_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Two-read / one-write register file with optional write-through
//               bypass and a pending-bit scoreboard for issue stalling.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NREGS  = DEFAULT_NREGS,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we3,
  input  logic [AW-1:0]                wa3,
  input  logic [WIDTH-1:0]             wd3,
  input  logic [AW-1:0]                ra1,
  input  logic [AW-1:0]                ra2,
  output logic [WIDTH-1:0]             rd1,
  output logic [WIDTH-1:0]             rd2,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_a,
  output logic                         busy1,
  output logic                         busy2,
  output logic                         stall,
  output logic [$clog2(NREGS+1)-1:0]   pend_cnt
);

  localparam bit c_BYPASS = (BYPASS != 0);
  localparam int c_CW     = $clog2(NREGS + 1);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic             w_wr;
  logic             w_hit1;
  logic             w_hit2;

  assign w_wr = we3 && (wa3 != '0);

  // Storage array; entry 0 is never written so it holds its reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[wa3] <= wd3;
    end
  end

  // Same-cycle forwarding hits; constant 0 when bypass is disabled.
  assign w_hit1 = c_BYPASS && w_wr && (wa3 == ra1);
  assign w_hit2 = c_BYPASS && w_wr && (wa3 == ra2);

  assign rd1 = (ra1 == '0) ? '0 : (w_hit1 ? wd3 : r_regs[ra1]);
  assign rd2 = (ra2 == '0) ? '0 : (w_hit2 ? wd3 : r_regs[ra2]);

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .CW    (c_CW)
  ) u_sb (
    .clk        (clk),
    .rst        (reset),
    .i_clr_en   (we3),
    .i_clr_a    (wa3),
    .i_set_en   (rsv_en),
    .i_set_a    (rsv_a),
    .i_ra1      (ra1),
    .i_ra2      (ra2),
    .i_fwd1     (w_hit1),
    .i_fwd2     (w_hit2),
    .o_busy1    (busy1),
    .o_busy2    (busy2),
    .o_pend_cnt (pend_cnt)
  );

  assign stall = busy1 | busy2;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Scoreboard bench driving a BYPASS=1 and a BYPASS=0 instance
//               with shared stimulus, checked against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset, we3, rsv_en;
  logic [4:0]  wa3, ra1, ra2, rsv_a;
  logic [31:0] wd3;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        busy1_b, busy2_b, stall_b, busy1_n, busy2_n, stall_n;
  logic [5:0]  cnt_b, cnt_n;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(32), .NREGS(32), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .rsv_en(rsv_en), .rsv_a(rsv_a),
    .busy1(busy1_b), .busy2(busy2_b), .stall(stall_b), .pend_cnt(cnt_b)
  );

  regfile_sb #(.WIDTH(32), .NREGS(32), .BYPASS(0)) dut_nob (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .rsv_en(rsv_en), .rsv_a(rsv_a),
    .busy1(busy1_n), .busy2(busy2_n), .stall(stall_n), .pend_cnt(cnt_n)
  );

  // Reference model: plain architectural state.
  logic [31:0] mem  [32];
  bit          pend [32];
  bit          model_valid = 0;

  typedef struct {
    bit          byp;
    logic [31:0] rd1, rd2;
    logic        b1, b2, st;
    logic [5:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t predict(bit byp);
    exp_t e;
    int   n = 0;
    bit   f1, f2;
    f1 = byp && we3 && (wa3 != 0) && (wa3 == ra1);
    f2 = byp && we3 && (wa3 != 0) && (wa3 == ra2);
    e.byp = byp;
    e.rd1 = (ra1 == 0) ? 32'h0 : (f1 ? wd3 : mem[ra1]);
    e.rd2 = (ra2 == 0) ? 32'h0 : (f2 ? wd3 : mem[ra2]);
    e.b1  = pend[ra1] && !f1;
    e.b2  = pend[ra2] && !f2;
    e.st  = e.b1 || e.b2;
    for (int i = 0; i < 32; i++) n += pend[i] ? 1 : 0;
    e.cnt = 6'(n);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // One clock cycle: drive inputs, queue the expected outputs, advance the model.
  task automatic step(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input bit rs, input logic [4:0] rsa);
    reset = r; we3 = we; wa3 = wa; wd3 = wd;
    ra1 = a1; ra2 = a2; rsv_en = rs; rsv_a = rsa;
    if (model_valid) begin
      q.push_back(predict(1'b1));
      q.push_back(predict(1'b0));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        mem[i]  = 32'h0;
        pend[i] = 0;
      end
      model_valid = 1;
    end else begin
      if (we && wa != 0) begin
        mem[wa]  = wd;
        pend[wa] = 0;
      end
      if (rs && rsa != 0) pend[rsa] = 1;
    end
    #1;
  endtask

  // Monitor: combinational outputs are settled mid-cycle; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.byp) begin
          chk("byp.rd1",   rd1_b,          e.rd1);
          chk("byp.rd2",   rd2_b,          e.rd2);
          chk("byp.busy1", 32'(busy1_b),   32'(e.b1));
          chk("byp.busy2", 32'(busy2_b),   32'(e.b2));
          chk("byp.stall", 32'(stall_b),   32'(e.st));
          chk("byp.cnt",   32'(cnt_b),     32'(e.cnt));
        end else begin
          chk("nob.rd1",   rd1_n,          e.rd1);
          chk("nob.rd2",   rd2_n,          e.rd2);
          chk("nob.busy1", 32'(busy1_n),   32'(e.b1));
          chk("nob.busy2", 32'(busy2_n),   32'(e.b2));
          chk("nob.stall", 32'(stall_n),   32'(e.st));
          chk("nob.cnt",   32'(cnt_n),     32'(e.cnt));
        end
      end
    end
  end

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    reset = 1'b1; we3 = 0; wa3 = 0; wd3 = 0; ra1 = 0; ra2 = 0; rsv_en = 0; rsv_a = 0;
    @(negedge clk);
    // Reset, then read r3/r0.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 3, 0, 0, 0);
    step(0, 0, 0, 0, 3, 0, 0, 0);
    // Write r3 with same-cycle read, then read again.
    step(0, 1, 3, 32'hC0DEBABE, 3, 3, 0, 0);
    step(0, 0, 0, 0, 3, 0, 0, 0);
    // Writes and reservations to r0 are ignored.
    step(0, 1, 0, 32'hBAADBEEF, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Reserve r5, r7; read busy; release r5 by write.
    step(0, 0, 0, 0, 5, 7, 1, 5);
    step(0, 0, 0, 0, 5, 7, 1, 7);
    step(0, 0, 0, 0, 5, 7, 0, 0);
    step(0, 1, 5, 32'h12345678, 5, 7, 0, 0);
    step(0, 0, 0, 0, 5, 7, 0, 0);
    // Re-reserving an already pending register leaves the count unchanged.
    step(0, 0, 0, 0, 7, 5, 1, 7);
    // Same-edge write and reserve of r9.
    step(0, 1, 9, 32'hAAAA5555, 9, 0, 1, 9);
    step(0, 0, 0, 0, 9, 9, 0, 0);
    // Reserve r4, r6, then reset together with a write to r4.
    step(0, 0, 0, 0, 4, 6, 1, 4);
    step(0, 0, 0, 0, 4, 6, 1, 6);
    step(1, 1, 4, 32'hFFFFFFFF, 4, 6, 0, 0);
    step(0, 0, 0, 0, 4, 6, 0, 0);

    // Randomised traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 1) == 1), rnd_addr(), $urandom(),
           rnd_addr(), rnd_addr(),
           ($urandom_range(0, 9) < 4), rnd_addr());
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Give the monitor a bounded window to drain the queue.
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
